// File: rtl/fp_pkg.sv
// Shared types, constants and IEEE-754 single-precision classification helpers
// for the FP add/sub sequencing controller.
package fp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_DONE  = 3'd4
  } fadd_state_t;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;
  localparam logic [7:0]  FP_EXP_MAX   = 8'hFF;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == FP_EXP_MAX) && (x[22:0] != 23'd0);
  endfunction

  // Quiet bit clear marks a signalling NaN
  function automatic logic fp_is_snan(input logic [31:0] x);
    return fp_is_nan(x) && !x[22];
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] x);
    return (x[30:23] == FP_EXP_MAX) && (x[22:0] == 23'd0);
  endfunction

endpackage

// File: rtl/fadd_sub_ctrl_if.sv
// Request/response handshakes between the FP issue logic (master) and the
// add/sub controller (slave).
interface fadd_sub_ctrl_if #(
  parameter int TAG_W = 5
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [2:0]       req_rm;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_rm, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_rm, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
  );
endinterface

// File: rtl/fp_special_detect.sv
// Combinational NaN/infinity short-circuit for FADD.S/FSUB.S: decides whether
// the datapath can be skipped and what the result and fflags are.
module fp_special_detect
  import fp_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        op,
  output logic        is_special,
  output logic [31:0] special_result,
  output logic [4:0]  special_flags
);

  logic sign_b_eff_s;
  logic any_nan_s;
  logic any_snan_s;
  logic a_inf_s;
  logic b_inf_s;

  assign sign_b_eff_s = b[31] ^ op;
  assign any_nan_s    = fp_is_nan(a) || fp_is_nan(b);
  assign any_snan_s   = fp_is_snan(a) || fp_is_snan(b);
  assign a_inf_s      = fp_is_inf(a);
  assign b_inf_s      = fp_is_inf(b);

  // Priority: NaN, then inf - inf (invalid), then a single/same-sign infinity
  always_comb begin
    is_special     = 1'b0;
    special_result = 32'd0;
    special_flags  = 5'd0;
    if (any_nan_s) begin
      is_special           = 1'b1;
      special_result       = FP_CANON_NAN;
      special_flags[FF_NV] = any_snan_s;
    end else if (a_inf_s && b_inf_s && (a[31] != sign_b_eff_s)) begin
      is_special           = 1'b1;
      special_result       = FP_CANON_NAN;
      special_flags[FF_NV] = 1'b1;
    end else if (a_inf_s) begin
      is_special     = 1'b1;
      special_result = {a[31], FP_EXP_MAX, 23'd0};
    end else if (b_inf_s) begin
      is_special     = 1'b1;
      special_result = {sign_b_eff_s, FP_EXP_MAX, 23'd0};
    end else begin
      is_special = 1'b0;
    end
  end

endmodule

// File: rtl/fadd_sub_ctrl.sv
// Sequencing controller for the shared single-precision add/sub datapath:
// ALIGN -> ADD -> NORM(xN) -> DONE, with a one-cycle bypass for NaN/inf operands.
module fadd_sub_ctrl
  import fp_pkg::*;
#(
  parameter int TAG_W       = 5,
  parameter int NORM_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  fadd_sub_ctrl_if.slave bus,
  output logic [31:0] dp_num1,
  output logic [31:0] dp_num2,
  output logic        dp_add_sub,
  output logic [2:0]  dp_rm,
  output logic        dp_en_align,
  output logic        dp_en_add,
  output logic        dp_en_norm,
  input  logic [31:0] dp_result,
  input  logic [4:0]  dp_flags
);

  localparam logic [1:0] NORM_LAST = 2'(NORM_CYCLES - 1);

  fadd_state_t      state_r;
  fadd_state_t      state_nxt_s;
  fadd_state_t      case_nxt_s;
  logic [1:0]       norm_cnt_r;
  logic [31:0]      rsp_result_r;
  logic [4:0]       rsp_flags_r;
  logic [TAG_W-1:0] rsp_tag_r;
  logic             req_ready_s;
  logic             accept_s;
  logic             norm_last_s;
  logic             is_special_s;
  logic [31:0]      special_result_s;
  logic [4:0]       special_flags_s;

  fp_special_detect u_special (
    .a              (bus.req_a),
    .b              (bus.req_b),
    .op             (bus.req_op),
    .is_special     (is_special_s),
    .special_result (special_result_s),
    .special_flags  (special_flags_s)
  );

  assign req_ready_s = reset_n && (state_r == ST_IDLE) && !flush;
  assign accept_s    = bus.req_valid && req_ready_s;
  assign norm_last_s = (state_r == ST_NORM) && (norm_cnt_r == NORM_LAST);

  assign bus.req_ready  = req_ready_s;
  assign bus.rsp_valid  = (state_r == ST_DONE);
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_flags  = rsp_flags_r;
  assign bus.rsp_tag    = rsp_tag_r;

  assign dp_en_align = (state_r == ST_ALIGN);
  assign dp_en_add   = (state_r == ST_ADD);
  assign dp_en_norm  = (state_r == ST_NORM);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    case_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case_nxt_s = is_special_s ? ST_DONE : ST_ALIGN;
        end else begin
          case_nxt_s = ST_IDLE;
        end
      end
      ST_ALIGN: case_nxt_s = ST_ADD;
      ST_ADD:   case_nxt_s = ST_NORM;
      ST_NORM: begin
        if (norm_last_s) begin
          case_nxt_s = ST_DONE;
        end else begin
          case_nxt_s = ST_NORM;
        end
      end
      ST_DONE: begin
        if (bus.rsp_ready) begin
          case_nxt_s = ST_IDLE;
        end else begin
          case_nxt_s = ST_DONE;
        end
      end
      default: case_nxt_s = ST_IDLE;
    endcase
    state_nxt_s = flush ? ST_IDLE : case_nxt_s;
  end

  // Normalize-stage dwell counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      norm_cnt_r <= 2'd0;
    end else if ((state_r == ST_NORM) && !flush) begin
      norm_cnt_r <= norm_cnt_r + 2'd1;
    end else begin
      norm_cnt_r <= 2'd0;
    end
  end

  // Operand/tag capture on accept; result capture from bypass or last NORM cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_num1      <= 32'd0;
      dp_num2      <= 32'd0;
      dp_add_sub   <= 1'b0;
      dp_rm        <= 3'd0;
      rsp_tag_r    <= '0;
      rsp_result_r <= 32'd0;
      rsp_flags_r  <= 5'd0;
    end else if (accept_s) begin
      dp_num1    <= bus.req_a;
      dp_num2    <= bus.req_b;
      dp_add_sub <= bus.req_op;
      dp_rm      <= bus.req_rm;
      rsp_tag_r  <= bus.req_tag;
      if (is_special_s) begin
        rsp_result_r <= special_result_s;
        rsp_flags_r  <= special_flags_s;
      end else begin
        rsp_result_r <= rsp_result_r;
        rsp_flags_r  <= rsp_flags_r;
      end
    end else if (norm_last_s && !flush) begin
      rsp_result_r <= dp_result;
      rsp_flags_r  <= dp_flags;
    end else begin
      rsp_result_r <= rsp_result_r;
      rsp_flags_r  <= rsp_flags_r;
    end
  end

endmodule

// File: tb/tb_fadd_sub_ctrl.sv
// Directed bench for fadd_sub_ctrl: a vector table on a NORM_CYCLES=1 instance
// plus back-pressure, flush and mid-operation reset sequences (second instance at NORM_CYCLES=3).
module tb_fadd_sub_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n1, rst_n3, flush1, flush3;
  logic [31:0] dp_num1_1, dp_num2_1, dp_result1, dp_num1_3, dp_num2_3, dp_result3;
  logic dp_add_sub1, dp_add_sub3, en_al1, en_ad1, en_no1, en_al3, en_ad3, en_no3;
  logic [2:0] dp_rm1, dp_rm3;
  logic [4:0] dp_flags1, dp_flags3;

  fadd_sub_ctrl_if #(.TAG_W(5)) bus1 ();
  fadd_sub_ctrl_if #(.TAG_W(5)) bus3 ();

  fadd_sub_ctrl #(.TAG_W(5), .NORM_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(rst_n1), .flush(flush1), .bus(bus1),
    .dp_num1(dp_num1_1), .dp_num2(dp_num2_1), .dp_add_sub(dp_add_sub1), .dp_rm(dp_rm1),
    .dp_en_align(en_al1), .dp_en_add(en_ad1), .dp_en_norm(en_no1),
    .dp_result(dp_result1), .dp_flags(dp_flags1)
  );

  fadd_sub_ctrl #(.TAG_W(5), .NORM_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(rst_n3), .flush(flush3), .bus(bus3),
    .dp_num1(dp_num1_3), .dp_num2(dp_num2_3), .dp_add_sub(dp_add_sub3), .dp_rm(dp_rm3),
    .dp_en_align(en_al3), .dp_en_add(en_ad3), .dp_en_norm(en_no3),
    .dp_result(dp_result3), .dp_flags(dp_flags3)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [2:0]  rm;
    logic [4:0]  tag;
    logic [31:0] dp_res;
    logic [4:0]  dp_fl;
    logic [31:0] exp_res;
    logic [4:0]  exp_fl;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  vec_t vecs[12];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic send1(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [2:0] rm, input logic [4:0] tag);
    @(negedge clk);
    bus1.req_a = a; bus1.req_b = b; bus1.req_op = op; bus1.req_rm = rm; bus1.req_tag = tag;
    bus1.req_valid = 1'b1;
    chk("req_ready_before_accept", {31'd0, bus1.req_ready}, 32'd1);
    @(posedge clk);
    #1 bus1.req_valid = 1'b0;
  endtask

  // Counts cycles after accept until rsp_valid; leaves caller at that negedge
  task automatic wait_rsp1(output int lat, output int na, output int nd, output int nn);
    lat = 0; na = 0; nd = 0; nn = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      na += int'(en_al1); nd += int'(en_ad1); nn += int'(en_no1);
      if (bus1.rsp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume1();
    bus1.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus1.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_after_handshake", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("req_ready_after_handshake", {31'd0, bus1.req_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, na, nd, nn;
    logic [31:0] hold_res;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 3'd0, 5'd7,  32'h40400000, 5'd0, 32'h40400000, 5'd0,      4, 1};
    vecs[1]  = '{32'h7F800001, 32'h3F800000, 1'b0, 3'd1, 5'd3,  32'h0,        5'd0, 32'h7FC00000, 5'b10000, 1, 0};
    vecs[2]  = '{32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 5'd1,  32'h0,        5'd0, 32'h7FC00000, 5'b10000, 1, 0};
    vecs[3]  = '{32'h7F800000, 32'h7F800000, 1'b0, 3'd2, 5'd2,  32'h0,        5'd0, 32'h7F800000, 5'd0,      1, 0};
    vecs[4]  = '{32'h7FC00001, 32'h3F800000, 1'b0, 3'd0, 5'd4,  32'h0,        5'd0, 32'h7FC00000, 5'd0,      1, 0};
    vecs[5]  = '{32'h3F800000, 32'hFF800000, 1'b1, 3'd3, 5'd5,  32'h0,        5'd0, 32'h7F800000, 5'd0,      1, 0};
    vecs[6]  = '{32'hFF800000, 32'h40000000, 1'b0, 3'd0, 5'd6,  32'h0,        5'd0, 32'hFF800000, 5'd0,      1, 0};
    vecs[7]  = '{32'h3F800000, 32'h7F800000, 1'b1, 3'd4, 5'd8,  32'h0,        5'd0, 32'hFF800000, 5'd0,      1, 0};
    vecs[8]  = '{32'h40000000, 32'h3F800000, 1'b1, 3'd1, 5'd31, 32'h3F800000, 5'd1, 32'h3F800000, 5'd1,      4, 1};
    vecs[9]  = '{32'hFF800000, 32'h7FA00000, 1'b0, 3'd0, 5'd9,  32'h0,        5'd0, 32'h7FC00000, 5'b10000, 1, 0};
    vecs[10] = '{32'hFF800000, 32'hFF800000, 1'b1, 3'd0, 5'd10, 32'h0,        5'd0, 32'h7FC00000, 5'b10000, 1, 0};
    vecs[11] = '{32'h00000000, 32'h80000000, 1'b0, 3'd2, 5'd11, 32'h00000000, 5'd0, 32'h00000000, 5'd0,      4, 1};

    rst_n1 = 1'b0; rst_n3 = 1'b0; flush1 = 1'b0; flush3 = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_op = 1'b0; bus1.req_rm = 3'd0; bus1.req_a = 32'd0;
    bus1.req_b = 32'd0; bus1.req_tag = 5'd0; bus1.rsp_ready = 1'b0;
    bus3.req_valid = 1'b0; bus3.req_op = 1'b0; bus3.req_rm = 3'd0; bus3.req_a = 32'd0;
    bus3.req_b = 32'd0; bus3.req_tag = 5'd0; bus3.rsp_ready = 1'b0;
    dp_result1 = 32'd0; dp_flags1 = 5'd0; dp_result3 = 32'd0; dp_flags3 = 5'd0;

    // Reset state
    #12;
    chk("rst_req_ready", {31'd0, bus1.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("rst_enables", {29'd0, en_al1, en_ad1, en_no1}, 32'd0);
    chk("rst_dp_num1", dp_num1_1, 32'd0);
    chk("rst_rsp_result", bus1.rsp_result, 32'd0);
    @(negedge clk);
    rst_n1 = 1'b1; rst_n3 = 1'b1;
    #1 chk("post_rst_req_ready", {31'd0, bus1.req_ready}, 32'd1);

    // Vector table on the NORM_CYCLES=1 instance
    for (int i = 0; i < 12; i++) begin
      dp_result1 = vecs[i].dp_res; dp_flags1 = vecs[i].dp_fl;
      send1(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].rm, vecs[i].tag);
      wait_rsp1(lat, na, nd, nn);
      chk("latency", lat, vecs[i].exp_lat);
      chk("rsp_result", bus1.rsp_result, vecs[i].exp_res);
      chk("rsp_flags", {27'd0, bus1.rsp_flags}, {27'd0, vecs[i].exp_fl});
      chk("rsp_tag", {27'd0, bus1.rsp_tag}, {27'd0, vecs[i].tag});
      chk("en_align_count", na, vecs[i].exp_en);
      chk("en_add_count", nd, vecs[i].exp_en);
      chk("en_norm_count", nn, vecs[i].exp_en);
      chk("dp_num1", dp_num1_1, vecs[i].a);
      chk("dp_num2", dp_num2_1, vecs[i].b);
      chk("dp_op_rm", {28'd0, dp_add_sub1, dp_rm1}, {28'd0, vecs[i].op, vecs[i].rm});
      consume1();
    end

    // Back-pressure: response held, competing request ignored
    dp_result1 = 32'h41200000; dp_flags1 = 5'b00001;
    send1(32'h40800000, 32'h40C00000, 1'b0, 3'd0, 5'd21);
    wait_rsp1(lat, na, nd, nn);
    hold_res = bus1.rsp_result;
    chk("bp_result", hold_res, 32'h41200000);
    bus1.req_valid = 1'b1; bus1.req_a = 32'h3F800000; bus1.req_b = 32'h3F800000; bus1.req_tag = 5'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd1);
      chk("bp_result_stable", bus1.rsp_result, hold_res);
      chk("bp_flags_stable", {27'd0, bus1.rsp_flags}, 32'd1);
      chk("bp_tag_stable", {27'd0, bus1.rsp_tag}, 32'd21);
      chk("bp_req_ready", {31'd0, bus1.req_ready}, 32'd0);
    end
    bus1.req_valid = 1'b0;
    consume1();

    // Flush in the ADD cycle
    send1(32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 5'd12);
    @(negedge clk);
    chk("fl_align", {31'd0, en_al1}, 32'd1);
    @(negedge clk);
    chk("fl_add", {31'd0, en_ad1}, 32'd1);
    flush1 = 1'b1;
    @(posedge clk);
    #1 flush1 = 1'b0;
    nn = 0; lat = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) chk("fl_req_ready_next", {31'd0, bus1.req_ready}, 32'd1);
      nn += int'(en_no1); lat += int'(bus1.rsp_valid);
    end
    chk("fl_norm_never", nn, 0);
    chk("fl_rsp_never", lat, 0);

    // Flush together with req_valid in IDLE: not accepted
    @(negedge clk);
    bus1.req_a = 32'h3F800000; bus1.req_b = 32'h40000000; bus1.req_valid = 1'b1; flush1 = 1'b1;
    #1 chk("flreq_ready", {31'd0, bus1.req_ready}, 32'd0);
    @(posedge clk);
    #1 bus1.req_valid = 1'b0; flush1 = 1'b0;
    @(negedge clk);
    chk("flreq_no_align", {31'd0, en_al1}, 32'd0);
    chk("flreq_idle", {31'd0, bus1.req_ready}, 32'd1);

    // Flush in DONE together with rsp_ready
    send1(32'h7F800000, 32'h3F800000, 1'b0, 3'd0, 5'd13);
    wait_rsp1(lat, na, nd, nn);
    chk("fldone_lat", lat, 1);
    flush1 = 1'b1; bus1.rsp_ready = 1'b1;
    @(posedge clk);
    #1 flush1 = 1'b0; bus1.rsp_ready = 1'b0;
    @(negedge clk);
    chk("fldone_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("fldone_req_ready", {31'd0, bus1.req_ready}, 32'd1);

    // NORM_CYCLES=3 instance: async reset in 2nd NORM cycle
    dp_result3 = 32'h40A00000; dp_flags3 = 5'd0;
    @(negedge clk);
    bus3.req_a = 32'h40000000; bus3.req_b = 32'h40400000; bus3.req_op = 1'b0; bus3.req_tag = 5'd17;
    bus3.req_valid = 1'b1;
    @(posedge clk);
    #1 bus3.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("n3_norm1", {31'd0, en_no3}, 32'd1);
    @(negedge clk);
    chk("n3_norm2", {31'd0, en_no3}, 32'd1);
    rst_n3 = 1'b0;
    #1;
    chk("n3_rst_enables", {29'd0, en_al3, en_ad3, en_no3}, 32'd0);
    chk("n3_rst_rsp_valid", {31'd0, bus3.rsp_valid}, 32'd0);
    chk("n3_rst_dp_num1", dp_num1_3, 32'd0);
    chk("n3_rst_req_ready", {31'd0, bus3.req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n3 = 1'b1;
    lat = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      lat += int'(bus3.rsp_valid);
    end
    chk("n3_no_rsp_after_reset", lat, 0);

    // NORM_CYCLES=3: full request, latency 6
    bus3.req_a = 32'h3F800000; bus3.req_b = 32'h40800000; bus3.req_tag = 5'd19;
    bus3.req_valid = 1'b1;
    @(posedge clk);
    #1 bus3.req_valid = 1'b0;
    lat = 0; nn = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      nn += int'(en_no3);
      if (bus3.rsp_valid) begin
        lat = c;
        break;
      end
    end
    chk("n3_latency", lat, 6);
    chk("n3_norm_count", nn, 3);
    chk("n3_result", bus3.rsp_result, 32'h40A00000);
    chk("n3_tag", {27'd0, bus3.rsp_tag}, 32'd19);
    bus3.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus3.rsp_ready = 1'b0;
    @(negedge clk);
    chk("n3_req_ready_after", {31'd0, bus3.req_ready}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
